// File: rtl/tube_p_bridge.sv
// tube_p_bridge: parasite-side bus sequencer for the Tube ULA parasite port.
// Optional polled access is enabled by defining TUBE_P_BRIDGE_POLL_EN.
module tube_p_bridge #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
`ifdef TUBE_P_BRIDGE_POLL_EN
    ,
    parameter int POLL_LIMIT    = 255
`endif
) (
    input  logic       p_clk,
    input  logic       p_rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [2:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
`ifdef TUBE_P_BRIDGE_POLL_EN
    input  logic       cpu_poll,
    output logic       cpu_err,
`endif
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic       cpu_busy,
    output logic       cpu_irq,
    output logic       cpu_nmi,
    output logic [2:0] p_addr,
    output logic       p_cs_b,
    output logic       p_rd_b,
    output logic       p_wr_b,
    output logic [7:0] p_data_out,
    output logic       p_data_oe,
    input  logic [7:0] p_data_in,
    input  logic       p_irq_b,
    input  logic       p_nmi_b
);

    // Phase counter reload values: a zero cycle count is stretched to one.
    localparam logic [3:0] SU_N =
        (SETUP_CYCLES <= 1) ? 4'd0 : 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] ST_N =
        (STROBE_CYCLES <= 1) ? 4'd0 : 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HD_N =
        (HOLD_CYCLES <= 1) ? 4'd0 : 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       op_we;
    logic       irq_s1;
    logic       irq_s2;
    logic       nmi_n1;
    logic       nmi_n2;
    logic       nmi_n3;

`ifdef TUBE_P_BRIDGE_POLL_EN
    localparam logic [7:0] PL_N =
        (POLL_LIMIT <= 1) ? 8'd0 : 8'(POLL_LIMIT - 1);

    logic [2:0] addr_q;
    logic [7:0] wdata_q;
    logic       req_we;
    logic       stat_ph;
    logic [1:0] stat_q;
    logic [7:0] pcnt;
`endif

    assign cpu_busy = (state != IDLE);
    assign cpu_irq  = ~irq_s2;
    assign cpu_nmi  = nmi_n3 & ~nmi_n2;

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_we      <= 1'b0;
            p_addr     <= 3'd0;
            p_cs_b     <= 1'b1;
            p_rd_b     <= 1'b1;
            p_wr_b     <= 1'b1;
            p_data_out <= 8'd0;
            p_data_oe  <= 1'b0;
            cpu_rdata  <= 8'd0;
            cpu_ack    <= 1'b0;
`ifdef TUBE_P_BRIDGE_POLL_EN
            addr_q     <= 3'd0;
            wdata_q    <= 8'd0;
            req_we     <= 1'b0;
            stat_ph    <= 1'b0;
            stat_q     <= 2'd0;
            pcnt       <= 8'd0;
            cpu_err    <= 1'b0;
`endif
        end else begin
            cpu_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state  <= SETUP;
                        cnt    <= SU_N;
                        p_cs_b <= 1'b0;
`ifdef TUBE_P_BRIDGE_POLL_EN
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        req_we  <= cpu_we;
                        pcnt    <= 8'd0;
                        if (cpu_poll && cpu_addr[0]) begin
                            stat_ph   <= 1'b1;
                            op_we     <= 1'b0;
                            p_addr    <= {cpu_addr[2:1], 1'b0};
                            p_data_oe <= 1'b0;
                        end else begin
                            stat_ph   <= 1'b0;
                            op_we     <= cpu_we;
                            p_addr    <= cpu_addr;
                            p_data_oe <= cpu_we;
                            if (cpu_we) p_data_out <= cpu_wdata;
                        end
`else
                        op_we     <= cpu_we;
                        p_addr    <= cpu_addr;
                        p_data_oe <= cpu_we;
                        if (cpu_we) p_data_out <= cpu_wdata;
`endif
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state  <= STROBE;
                        cnt    <= ST_N;
                        p_rd_b <= op_we;
                        p_wr_b <= ~op_we;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        state  <= HOLD;
                        cnt    <= HD_N;
                        p_rd_b <= 1'b1;
                        p_wr_b <= 1'b1;
`ifdef TUBE_P_BRIDGE_POLL_EN
                        if (!op_we && stat_ph) stat_q <= p_data_in[7:6];
                        if (!op_we && !stat_ph) cpu_rdata <= p_data_in;
`else
                        if (!op_we) cpu_rdata <= p_data_in;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
`ifdef TUBE_P_BRIDGE_POLL_EN
                        if (!stat_ph) begin
                            state     <= IDLE;
                            p_cs_b    <= 1'b1;
                            p_data_oe <= 1'b0;
                            cpu_ack   <= 1'b1;
                            cpu_err   <= 1'b0;
                        end else if (req_we ? stat_q[0] : stat_q[1]) begin
                            // Device ready: run the real access on the data register.
                            stat_ph   <= 1'b0;
                            state     <= SETUP;
                            cnt       <= SU_N;
                            op_we     <= req_we;
                            p_addr    <= addr_q;
                            p_data_oe <= req_we;
                            if (req_we) p_data_out <= wdata_q;
                        end else if (pcnt == PL_N) begin
                            state     <= IDLE;
                            p_cs_b    <= 1'b1;
                            p_data_oe <= 1'b0;
                            cpu_ack   <= 1'b1;
                            cpu_err   <= 1'b1;
                        end else begin
                            pcnt  <= pcnt + 8'd1;
                            state <= SETUP;
                            cnt   <= SU_N;
                        end
`else
                        state     <= IDLE;
                        p_cs_b    <= 1'b1;
                        p_data_oe <= 1'b0;
                        cpu_ack   <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
            nmi_n1 <= 1'b1;
            nmi_n2 <= 1'b1;
            nmi_n3 <= 1'b1;
        end else begin
            irq_s1 <= p_irq_b;
            irq_s2 <= irq_s1;
            nmi_n1 <= p_nmi_b;
            nmi_n2 <= nmi_n1;
            nmi_n3 <= nmi_n2;
        end
    end

endmodule
